// File: rtl/inst_fetch_responder.sv
// Memory-side responder for the IF stage: turns a fetch address into a req/gnt + rvalid
// read of instruction memory and stalls IF until the word is ready. Optional one-entry fetch buffer: FETCH_BUF_EN.
module inst_fetch_responder #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr_i,
  input  logic              fetch_en_i,
  input  logic              flush_i,
  output logic [31:0]       inst_o,
  output logic              mem_stall_o,
  output logic              misalign_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned     CNT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              kill_q, kill_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              err_q;
  logic              misalign_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] addr_q;

  logic              aligned;
  logic              load_addr;
  logic              inst_load;
  logic [31:0]       inst_d;
  logic              capture;
  logic              misalign_set;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              buf_hit;
  logic [31:0]       buf_data;

  assign aligned = (inst_addr_i[1:0] == 2'b00);

`ifdef FETCH_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [31:0]       buf_data_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      buf_valid_q <= 1'b0;
    end else if (capture) begin
      buf_valid_q <= 1'b1;
    end
  end

  // NOTE: buffer addr/data are not reset; the valid bit alone gates their use.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_addr_q <= addr_q;
      buf_data_q <= mem_rdata_i;
    end
  end

  assign buf_hit  = buf_valid_q && (buf_addr_q == inst_addr_i[ADDR_W-1:0]);
  assign buf_data = buf_data_q;
`else
  assign buf_hit  = 1'b0;
  assign buf_data = NOP_INST;
`endif

  // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    load_addr    = 1'b0;
    inst_load    = 1'b0;
    inst_d       = NOP_INST;
    capture      = 1'b0;
    misalign_set = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          inst_load = 1'b1;
        end else if (fetch_en_i) begin
          if (!aligned) begin
            misalign_set = 1'b1;
            inst_load    = 1'b1;
            state_d      = S_DONE;
          end else if (buf_hit) begin
            inst_load = 1'b1;
            inst_d    = buf_data;
            state_d   = S_DONE;
          end else begin
            load_addr = 1'b1;
            kill_d    = 1'b0;
            state_d   = S_REQ;
          end
        end
      end

      S_REQ: begin
        // A flush cannot withdraw the request; it is remembered until the grant.
        if (flush_i) begin
          inst_load = 1'b1;
        end
        if (mem_gnt_i) begin
          kill_d = 1'b0;
          if (kill_q || flush_i) begin
            state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
          end else if (mem_rvalid_i) begin
            capture   = 1'b1;
            inst_load = 1'b1;
            inst_d    = mem_rdata_i;
            state_d   = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (flush_i) begin
          inst_load = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = mem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid_i) begin
          capture   = 1'b1;
          inst_load = 1'b1;
          inst_d    = mem_rdata_i;
          cnt_clr   = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        if (flush_i) begin
          inst_load = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q     <= NOP_INST;
      addr_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_set;
      if (inst_load) begin
        inst_q <= inst_d;
      end
      if (load_addr) begin
        addr_q <= inst_addr_i[ADDR_W-1:0];
      end
    end
  end

  // The wait counter saturates at WAIT_MAX; the slow response is still awaited.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (cnt_clr) begin
      wait_cnt_q <= '0;
    end else if (cnt_inc) begin
      if (wait_cnt_q == CNT_MAX) begin
        err_q <= 1'b1;
      end else begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_addr_o  = addr_q;
  assign misalign_o  = misalign_q;
  assign err_o       = err_q;
  assign inst_o      = flush_i ? NOP_INST : inst_q;
  assign mem_stall_o = rst                 ? 1'b0 :
                       (state_q == S_DRAIN) ? fetch_en_i :
                       (fetch_en_i && !flush_i && (state_q != S_DONE));

  a_req_held : assert property (@(posedge clk) disable iff (rst)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o)));

  a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
    (state_q == S_DONE) |=> (state_q == S_IDLE));

  a_err_sticky : assert property (@(posedge clk) disable iff (rst)
    err_q |=> err_q);

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: table of fetch vectors against a bench-side
// memory responder, a scoreboard of expected instructions, and hand sequences for flush and timeout.
module tb_inst_fetch_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        fetch_en;
  logic        flush;
  logic [31:0] inst_o;
  logic        mem_stall_o;
  logic        misalign_o;
  logic        err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] exp_inst;
    logic        exp_mis;
    int          exp_hs;
    int          exp_req;
    int          exp_cyc;
  } fetch_vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t       sb[$];
  fetch_vec_t vecs[9];

  inst_fetch_responder dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr_i  (inst_addr),
    .fetch_en_i   (fetch_en),
    .flush_i      (flush),
    .inst_o       (inst_o),
    .mem_stall_o  (mem_stall_o),
    .misalign_o   (misalign_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (gnt),
    .mem_rvalid_i (rvalid),
    .mem_rdata_i  (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one fetch starting in IDLE and plays instruction memory for it.
  task automatic do_fetch(input fetch_vec_t v, input string tag);
    int   cyc = 0;
    int   req_cyc = 0;
    int   hs = 0;
    int   rcnt = 0;
    int   bad_addr = 0;
    bit   granted = 1'b0;
    bit   done = 1'b0;
    exp_t e;
    sb.push_back('{inst: v.exp_inst, mis: v.exp_mis});
    while (!done && cyc < 600) begin
      @(negedge clk);
      fetch_en  = 1'b1;
      flush     = 1'b0;
      inst_addr = v.addr;
      gnt       = 1'b0;
      rvalid    = 1'b0;
      #1;
      cyc++;
      if (cyc == 1) check({tag, " misalign low at start"}, 32'(misalign_o), 32'd0);
      if (mem_req_o) begin
        req_cyc++;
        if (mem_addr_o !== v.addr) bad_addr++;
        if (req_cyc > v.gnt_dly) begin
          gnt     = 1'b1;
          hs++;
          granted = 1'b1;
          if (v.rv_dly == 0) rvalid = 1'b1;
          else rcnt = v.rv_dly;
        end
      end else if (granted && rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rvalid = 1'b1;
      end
      rdata = rvalid ? v.rdata : ~v.rdata;
      if (!mem_stall_o) begin
        done = 1'b1;
        e = sb.pop_front();
        check({tag, " inst"}, inst_o, e.inst);
        check({tag, " misalign"}, 32'(misalign_o), 32'(e.mis));
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    if (!done && sb.size() > 0) void'(sb.pop_front());
    check({tag, " cycles"}, cyc, v.exp_cyc);
    check({tag, " req cycles"}, req_cyc, v.exp_req);
    check({tag, " handshakes"}, hs, v.exp_hs);
    check({tag, " addr errors"}, bad_addr, 0);
  endtask

  initial begin
    fetch_vec_t fv;
    exp_t       e;

    //            addr          rdata         gnt rv  exp_inst      mis  hs req cyc
    vecs[0] = '{32'h00000000, 32'h00500093, 0, 0, 32'h00500093, 1'b0, 1, 1, 3};
    vecs[1] = '{32'h00000004, 32'h00A00113, 2, 3, 32'h00A00113, 1'b0, 1, 3, 8};
    vecs[2] = '{32'h00000006, 32'h11111111, 0, 0, NOP,          1'b1, 0, 0, 2};
    vecs[3] = '{32'h00000010, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 1'b0, 1, 2, 4};
    vecs[4] = '{32'h00000020, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 1'b0, 1, 1, 4};
    vecs[5] = '{32'h00000008, 32'h12345678, 0, 0, 32'h12345678, 1'b0, 1, 1, 3};
`ifdef FETCH_BUF_EN
    vecs[6] = '{32'h00000008, 32'h87654321, 0, 0, 32'h12345678, 1'b0, 0, 0, 2};
`else
    vecs[6] = '{32'h00000008, 32'h12345678, 0, 0, 32'h12345678, 1'b0, 1, 1, 3};
`endif
    vecs[7] = '{32'h00000003, 32'h22222222, 0, 0, NOP,          1'b1, 0, 0, 2};
    vecs[8] = '{32'hFFFFFFFC, 32'hAAAA5555, 3, 2, 32'hAAAA5555, 1'b0, 1, 4, 8};

    rst = 1'b1; fetch_en = 1'b1; flush = 1'b0; inst_addr = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("stall during reset", 32'(mem_stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b0;
    #1;
    check("reset inst", inst_o, NOP);
    check("reset req", 32'(mem_req_o), 32'd0);
    check("reset addr", mem_addr_o, 32'h0);
    check("reset misalign", 32'(misalign_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);

    for (int i = 0; i < 9; i++) do_fetch(vecs[i], $sformatf("vec%0d", i));

    // Flush while waiting for rvalid; the stale response must be dropped.
    @(negedge clk); fetch_en = 1'b1; flush = 1'b0; inst_addr = 32'h40; gnt = 1'b0; rvalid = 1'b0;
    #1;
    @(negedge clk); #1;
    check("wflush req", 32'(mem_req_o), 32'd1);
    check("wflush addr", mem_addr_o, 32'h40);
    gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; flush = 1'b1; #1;
    check("wflush stall", 32'(mem_stall_o), 32'd0);
    check("wflush inst", inst_o, NOP);
    @(negedge clk); flush = 1'b0; inst_addr = 32'h100; #1;
    check("drain stall follows fetch_en", 32'(mem_stall_o), 32'd1);
    check("drain no req", 32'(mem_req_o), 32'd0);
    @(negedge clk); fetch_en = 1'b0; rvalid = 1'b1; rdata = 32'hBADBAD00; #1;
    @(negedge clk); rvalid = 1'b0; #1;
    check("stale data dropped", inst_o, NOP);
    check("idle after drain", 32'(mem_req_o), 32'd0);
    fv = '{32'h00000100, 32'h00100073, 0, 0, 32'h00100073, 1'b0, 1, 1, 3};
    do_fetch(fv, "refetch");

    // Flush while the request is still waiting for its grant.
    @(negedge clk); fetch_en = 1'b1; flush = 1'b0; inst_addr = 32'h200; gnt = 1'b0; rvalid = 1'b0;
    #1;
    @(negedge clk); flush = 1'b1; #1;
    check("rflush req", 32'(mem_req_o), 32'd1);
    check("rflush stall", 32'(mem_stall_o), 32'd0);
    check("rflush inst", inst_o, NOP);
    @(negedge clk); flush = 1'b0; #1;
    check("rflush req held", 32'(mem_req_o), 32'd1);
    check("rflush addr held", mem_addr_o, 32'h200);
    check("rflush stall after", 32'(mem_stall_o), 32'd1);
    gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; fetch_en = 1'b0; #1;
    check("rflush drain no req", 32'(mem_req_o), 32'd0);
    rvalid = 1'b1; rdata = 32'h55555555;
    @(negedge clk); rvalid = 1'b0; #1;
    check("rflush data dropped", inst_o, NOP);

    // Response withheld past WAIT_MAX: err_o must set, stick, and data still arrive.
    @(negedge clk); fetch_en = 1'b1; inst_addr = 32'h80; gnt = 1'b0; rvalid = 1'b0; #1;
    check("timeout err low", 32'(err_o), 32'd0);
    @(negedge clk); #1;
    check("timeout req", 32'(mem_req_o), 32'd1);
    gnt = 1'b1;
    sb.push_back('{inst: 32'h0BADF00D, mis: 1'b0});
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      gnt    = 1'b0;
      rvalid = (k == 300);
      rdata  = (k == 300) ? 32'h0BADF00D : 32'h0;
      #1;
      if (k == 100) check("timeout stall", 32'(mem_stall_o), 32'd1);
      if (k == 250) check("err low before limit", 32'(err_o), 32'd0);
      if (k == 260) check("err high after limit", 32'(err_o), 32'd1);
    end
    @(negedge clk); rvalid = 1'b0; #1;
    check("timeout done", 32'(mem_stall_o), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("timeout inst", inst_o, e.inst);
    end
    fv = '{32'h00000300, 32'h00000001, 1, 1, 32'h00000001, 1'b0, 1, 2, 5};
    do_fetch(fv, "after timeout");
    check("err sticky", 32'(err_o), 32'd1);
    check("scoreboard empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
